// File: rtl/psram_arbiter_pkg.sv
// psram_arbiter_pkg: shared definitions for the psram arbiter and future psram clients.
//   PsramAw / PsramDw : psram word-address and data widths
//   arb_state_e       : arbiter FSM state encodings
//   owner_e           : requester codes as seen on o_owner
//   psram_req_t       : latched transaction fields presented to the controller
package psram_arbiter_pkg;

  localparam int unsigned PsramAw = 24;
  localparam int unsigned PsramDw = 16;

  typedef enum logic [2:0] {
    StStartup = 3'd0,
    StIdle    = 3'd1,
    StIssue   = 3'd2,
    StWait    = 3'd3,
    StDrain   = 3'd4
  } arb_state_e;

  typedef enum logic {
    OwnerVid = 1'b0,
    OwnerCmd = 1'b1
  } owner_e;

  typedef struct packed {
    logic               we;
    logic [PsramAw-1:0] addr;
    logic [PsramDw-1:0] din;
  } psram_req_t;

  // A transaction is outstanding at the controller (watchdog runs only here).
  function automatic logic in_flight(arb_state_e s);
    return (s == StIssue) || (s == StWait);
  endfunction

endpackage

// File: rtl/psram_arbiter_watchdog.sv
// psram_arbiter_watchdog: cycle counter that flags a hung bus transaction.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   clr_i    : synchronous clear (takes priority over en_i)
//   en_i     : count this cycle
//   expire_o : high on the TIMEOUT-th consecutive enabled cycle since the last clear
module psram_arbiter_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  // The first enabled cycle sees cnt_q == 0, so CntLast marks the TIMEOUT-th cycle.
  assign expire_o = en_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one psram controller between the video fetch port (VID, read-only)
// and the command/host port (CMD, read/write). One transaction at a time, CMD starvation
// guard, and a watchdog that aborts a hung controller.
//   i_clk, i_rst                       : clock, asynchronous active-high reset
//   i_vid_req/i_vid_addr               : VID read request (held until o_vid_ack)
//   o_vid_ack/o_vid_done/o_vid_rdata   : VID accept pulse, completion pulse, read data
//   i_cmd_req/i_cmd_we/addr/din        : CMD request (held until o_cmd_ack)
//   o_cmd_ack/o_cmd_done/o_cmd_rdata   : CMD accept pulse, completion pulse, read data
//   o_stb/o_we/o_addr/o_din            : to the psram controller
//   i_busy/i_done/i_dout               : from the psram controller
//   o_owner                            : 0=VID, 1=CMD, owner of current/last transaction
//   o_timeout                          : sticky watchdog-abort flag
module psram_arbiter
  import psram_arbiter_pkg::*;
#(
  parameter int unsigned        STARVE_LIMIT = 4,
  parameter int unsigned        TIMEOUT      = 1024,
  parameter logic [PsramDw-1:0] ABORT_DATA   = 16'hDEAD
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_vid_req,
  input  logic [PsramAw-1:0] i_vid_addr,
  output logic               o_vid_ack,
  output logic               o_vid_done,
  output logic [PsramDw-1:0] o_vid_rdata,
  input  logic               i_cmd_req,
  input  logic               i_cmd_we,
  input  logic [PsramAw-1:0] i_cmd_addr,
  input  logic [PsramDw-1:0] i_cmd_din,
  output logic               o_cmd_ack,
  output logic               o_cmd_done,
  output logic [PsramDw-1:0] o_cmd_rdata,
  output logic               o_stb,
  output logic               o_we,
  output logic [PsramAw-1:0] o_addr,
  output logic [PsramDw-1:0] o_din,
  input  logic               i_busy,
  input  logic               i_done,
  input  logic [PsramDw-1:0] i_dout,
  output logic               o_owner,
  output logic               o_timeout
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  arb_state_e         state_d, state_q;
  psram_req_t         req_d, req_q;
  owner_e             owner_d, owner_q;
  logic [3:0]         starve_d, starve_q;
  logic               stb_d, stb_q;
  logic               we_d, we_q;
  logic               vid_ack_d, vid_ack_q;
  logic               cmd_ack_d, cmd_ack_q;
  logic               vid_done_d, vid_done_q;
  logic               cmd_done_d, cmd_done_q;
  logic [PsramDw-1:0] vid_rdata_d, vid_rdata_q;
  logic [PsramDw-1:0] cmd_rdata_d, cmd_rdata_q;
  logic               timeout_d, timeout_q;

  logic               wd_run;
  logic               wd_expire;
  logic               finish;
  logic               capture;
  logic               abort;
  logic [PsramDw-1:0] resp_data;

  assign wd_run = in_flight(state_q);

  psram_arbiter_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .clr_i    (~wd_run),
    .en_i     (wd_run),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    stb_d       = stb_q;
    we_d        = we_q;
    vid_ack_d   = 1'b0;
    cmd_ack_d   = 1'b0;
    vid_done_d  = 1'b0;
    cmd_done_d  = 1'b0;
    vid_rdata_d = vid_rdata_q;
    cmd_rdata_d = cmd_rdata_q;
    timeout_d   = timeout_q;
    finish      = 1'b0;
    capture     = 1'b0;
    abort       = 1'b0;
    resp_data   = '0;

    unique case (state_q)
      StStartup: begin
        // Controller still initialising.
        if (!i_busy) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (!i_cmd_req) begin
          starve_d = '0;
        end
        if (i_cmd_req && (!i_vid_req || (starve_q == StarveMax))) begin
          req_d     = '{we: i_cmd_we, addr: i_cmd_addr, din: i_cmd_din};
          owner_d   = OwnerCmd;
          stb_d     = 1'b1;
          we_d      = i_cmd_we;
          cmd_ack_d = 1'b1;
          starve_d  = '0;
          state_d   = StIssue;
        end else if (i_vid_req) begin
          req_d     = '{we: 1'b0, addr: i_vid_addr, din: '0};
          owner_d   = OwnerVid;
          stb_d     = 1'b1;
          we_d      = 1'b0;
          vid_ack_d = 1'b1;
          if (i_cmd_req && (starve_q != StarveMax)) begin
            starve_d = starve_q + 1'b1;
          end
          state_d   = StIssue;
        end
      end

      StIssue: begin
        if (wd_expire) begin
          abort = 1'b1;
        end else if (i_busy) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StWait;
        end
      end

      StWait: begin
        // A done arriving on the expiry cycle still completes normally.
        if (i_done) begin
          finish  = 1'b1;
          capture = 1'b1;
        end else if (wd_expire) begin
          abort = 1'b1;
        end else if (!i_busy) begin
          finish = 1'b1;
        end
      end

      StDrain: begin
        if (!i_busy) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StStartup;
      end
    endcase

    if (finish || abort) begin
      vid_done_d = (owner_q == OwnerVid);
      cmd_done_d = (owner_q == OwnerCmd);
      resp_data  = abort ? ABORT_DATA : i_dout;
      // Writes never touch rdata; a busy drop without done leaves it as well.
      if (!req_q.we && (capture || abort)) begin
        if (owner_q == OwnerVid) begin
          vid_rdata_d = resp_data;
        end else begin
          cmd_rdata_d = resp_data;
        end
      end
      state_d = abort ? StDrain : StIdle;
    end

    if (abort) begin
      stb_d     = 1'b0;
      we_d      = 1'b0;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StStartup;
      req_q       <= '0;
      owner_q     <= OwnerVid;
      starve_q    <= '0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      vid_ack_q   <= 1'b0;
      cmd_ack_q   <= 1'b0;
      vid_done_q  <= 1'b0;
      cmd_done_q  <= 1'b0;
      vid_rdata_q <= '0;
      cmd_rdata_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      vid_ack_q   <= vid_ack_d;
      cmd_ack_q   <= cmd_ack_d;
      vid_done_q  <= vid_done_d;
      cmd_done_q  <= cmd_done_d;
      vid_rdata_q <= vid_rdata_d;
      cmd_rdata_q <= cmd_rdata_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_vid_ack   = vid_ack_q;
  assign o_vid_done  = vid_done_q;
  assign o_vid_rdata = vid_rdata_q;
  assign o_cmd_ack   = cmd_ack_q;
  assign o_cmd_done  = cmd_done_q;
  assign o_cmd_rdata = cmd_rdata_q;
  assign o_stb       = stb_q;
  assign o_we        = we_q;
  assign o_addr      = req_q.addr;
  assign o_din       = req_q.din;
  assign o_owner     = owner_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: directed self-checking bench for psram_arbiter with a behavioural
// psram controller model and a read-data / grant-order scoreboard.
module tb_psram_arbiter;

  typedef logic [79:0] w_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vid_req = 1'b0;
  logic [23:0] vid_addr = '0;
  logic        cmd_req = 1'b0;
  logic        cmd_we = 1'b0;
  logic [23:0] cmd_addr = '0;
  logic [15:0] cmd_din = '0;
  logic        busy_m = 1'b1;
  logic        done_m = 1'b0;
  logic [15:0] dout_m = '0;

  logic        o_vid_ack, o_vid_done, o_cmd_ack, o_cmd_done;
  logic [15:0] o_vid_rdata, o_cmd_rdata, o_din;
  logic        o_stb, o_we, o_owner, o_timeout;
  logic [23:0] o_addr;

  int n_checks = 0;
  int n_fail = 0;

  // Controller model control: 0=init (busy held), 1=normal, 2=hung (never accepts).
  int mode = 0;
  int lat = 3;

  logic [15:0] ctl_mem [logic [23:0]];
  logic [15:0] exp_mem [logic [23:0]];
  logic [15:0] sb_q [$];
  logic        gq [$];
  logic [15:0] exp_cmd_rdata = '0;

  always #5 clk = ~clk;

  psram_arbiter #(
    .STARVE_LIMIT (4),
    .TIMEOUT      (1024),
    .ABORT_DATA   (16'hDEAD)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_vid_req   (vid_req),
    .i_vid_addr  (vid_addr),
    .o_vid_ack   (o_vid_ack),
    .o_vid_done  (o_vid_done),
    .o_vid_rdata (o_vid_rdata),
    .i_cmd_req   (cmd_req),
    .i_cmd_we    (cmd_we),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_din   (cmd_din),
    .o_cmd_ack   (o_cmd_ack),
    .o_cmd_done  (o_cmd_done),
    .o_cmd_rdata (o_cmd_rdata),
    .o_stb       (o_stb),
    .o_we        (o_we),
    .o_addr      (o_addr),
    .o_din       (o_din),
    .i_busy      (busy_m),
    .i_done      (done_m),
    .i_dout      (dout_m),
    .o_owner     (o_owner),
    .o_timeout   (o_timeout)
  );

  // Controller model: accepts a strobe, stays busy for lat cycles, then drops busy
  // together with a one-cycle done carrying the read data.
  int          cnt_m = 0;
  logic [23:0] cur_addr = '0;
  always begin
    @(posedge clk);
    #3;
    done_m = 1'b0;
    if (mode == 0) begin
      busy_m = 1'b1;
      cnt_m  = 0;
    end else if (mode == 2) begin
      busy_m = 1'b0;
      cnt_m  = 0;
    end else if (busy_m) begin
      if (cnt_m <= 1) begin
        done_m = (cnt_m == 1);
        dout_m = ctl_mem.exists(cur_addr) ? ctl_mem[cur_addr] : 16'h0000;
        busy_m = 1'b0;
        cnt_m  = 0;
      end else begin
        cnt_m = cnt_m - 1;
      end
    end else if (o_stb) begin
      busy_m   = 1'b1;
      cnt_m    = lat;
      cur_addr = o_addr;
      if (o_we) ctl_mem[o_addr] = o_din;
    end
  end

  task automatic check(input string tag, input w_t obs, input w_t exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic w_t all_outs();
    return {o_vid_ack, o_vid_done, o_vid_rdata, o_cmd_ack, o_cmd_done, o_cmd_rdata,
            o_stb, o_we, o_addr, o_din, o_owner, o_timeout};
  endfunction

  // One request through ack and done; expected rdata is pushed before driving.
  task automatic do_txn(input logic is_cmd, input logic we, input logic [23:0] addr,
                        input logic [15:0] din, input logic hung, input string tag);
    logic [15:0] exp;
    logic        got;
    if (we) begin
      exp_mem[addr] = din;
      exp = exp_cmd_rdata;
    end else if (hung) begin
      exp = 16'hDEAD;
    end else begin
      exp = exp_mem.exists(addr) ? exp_mem[addr] : 16'h0000;
    end
    sb_q.push_back(exp);
    if (is_cmd) begin
      cmd_req = 1'b1; cmd_we = we; cmd_addr = addr; cmd_din = din;
    end else begin
      vid_req = 1'b1; vid_addr = addr;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (is_cmd ? o_cmd_ack : o_vid_ack) got = 1'b1;
    end
    check({tag, "_ack"}, w_t'(got), w_t'(1'b1));
    check({tag, "_owner"}, w_t'(o_owner), w_t'(is_cmd));
    check({tag, "_addr"}, w_t'(o_addr), w_t'(addr));
    check({tag, "_we"}, w_t'({o_stb, o_we}), w_t'({1'b1, we}));
    if (is_cmd && we) check({tag, "_din"}, w_t'(o_din), w_t'(din));
    vid_req = 1'b0;
    cmd_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (is_cmd ? o_cmd_done : o_vid_done) got = 1'b1;
    end
    check({tag, "_done"}, w_t'(got), w_t'(1'b1));
    exp = sb_q.pop_front();
    check({tag, "_rdata"}, w_t'(is_cmd ? o_cmd_rdata : o_vid_rdata), w_t'(exp));
    if (is_cmd) exp_cmd_rdata = exp;
  endtask

  initial begin
    int          cnt;
    int          acks;
    int          stb_cycles;
    logic        got;
    logic [15:0] exp;

    // Reset state, then controller init with VID already pending.
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    vid_req = 1'b1;
    vid_addr = 24'h000040;
    sb_q.push_back(16'h0000);
    rst = 1'b0;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_vid_ack) cnt++;
    end
    check("startup_no_ack", w_t'(cnt), w_t'(0));
    mode = 1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (!busy_m) got = 1'b1;
    end
    check("startup_busy_low", w_t'(got), w_t'(1'b1));
    @(negedge clk);
    check("startup_idle_cycle", w_t'(o_vid_ack), w_t'(1'b0));
    @(negedge clk);
    check("startup_ack", w_t'(o_vid_ack), w_t'(1'b1));
    vid_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (o_vid_done) got = 1'b1;
    end
    check("startup_done", w_t'(got), w_t'(1'b1));
    exp = sb_q.pop_front();
    check("startup_rdata", w_t'(o_vid_rdata), w_t'(exp));

    // Write/read patterns, including the top address.
    do_txn(1'b1, 1'b1, 24'h000010, 16'hA5A5, 1'b0, "cmd_wr10");
    do_txn(1'b1, 1'b0, 24'h000010, 16'h0000, 1'b0, "cmd_rd10");
    do_txn(1'b1, 1'b1, 24'h123456, 16'h5A5A, 1'b0, "cmd_wr_mid");
    do_txn(1'b1, 1'b1, 24'hFFFFFF, 16'hFFFF, 1'b0, "cmd_wr_top");
    do_txn(1'b0, 1'b0, 24'h123456, 16'h0000, 1'b0, "vid_rd_mid");
    do_txn(1'b0, 1'b0, 24'hFFFFFF, 16'h0000, 1'b0, "vid_rd_top");
    do_txn(1'b1, 1'b0, 24'h123456, 16'h0000, 1'b0, "cmd_rd_mid");

    // Both requesters held high: CMD wins after four VID grants in a row.
    lat = 2;
    gq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vid_req = 1'b1; vid_addr = 24'h000020;
    cmd_req = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h000010;
    acks = 0;
    for (int i = 0; i < 500 && acks < 10; i++) begin
      @(negedge clk);
      if (o_vid_ack && o_cmd_ack) check("dual_ack", w_t'(1'b1), w_t'(1'b0));
      if ((o_vid_ack || o_cmd_ack) && gq.size() > 0) begin
        check($sformatf("grant_%0d", acks), w_t'(o_cmd_ack), w_t'(gq.pop_front()));
        acks++;
      end
    end
    vid_req = 1'b0;
    cmd_req = 1'b0;
    check("grant_count", w_t'(acks), w_t'(10));
    repeat (20) @(negedge clk);

    // Done lands on the exact watchdog expiry cycle: normal completion.
    lat = 1023;
    do_txn(1'b1, 1'b0, 24'h000010, 16'h0000, 1'b0, "exact_expiry");
    check("exact_no_timeout", w_t'(o_timeout), w_t'(1'b0));
    lat = 3;

    // Hung controller: strobe held for TIMEOUT cycles, abort data, sticky flag.
    mode = 2;
    vid_req = 1'b1;
    vid_addr = 24'h000020;
    sb_q.push_back(16'hDEAD);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (o_vid_ack) got = 1'b1;
    end
    check("hang_ack", w_t'(got), w_t'(1'b1));
    vid_req = 1'b0;
    stb_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!o_stb) break;
      stb_cycles++;
      @(negedge clk);
    end
    check("hang_stb_cycles", w_t'(stb_cycles), w_t'(1024));
    check("hang_done", w_t'(o_vid_done), w_t'(1'b1));
    exp = sb_q.pop_front();
    check("hang_rdata", w_t'(o_vid_rdata), w_t'(exp));
    check("hang_timeout", w_t'(o_timeout), w_t'(1'b1));
    mode = 1;
    do_txn(1'b1, 1'b0, 24'h000010, 16'h0000, 1'b0, "after_hang");
    check("timeout_sticky", w_t'(o_timeout), w_t'(1'b1));

    // Reset during the WAIT phase of a VID read.
    lat = 20;
    vid_req = 1'b1;
    vid_addr = 24'h000010;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (o_vid_ack) got = 1'b1;
    end
    check("rstwait_ack", w_t'(got), w_t'(1'b1));
    vid_req = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    mode = 0;
    #1;
    check("rstwait_outputs", all_outs(), '0);
    exp_cmd_rdata = '0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_vid_done) cnt++;
    end
    check("rstwait_no_done", w_t'(cnt), w_t'(0));
    rst = 1'b0;
    vid_req = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_vid_ack) cnt++;
    end
    check("rstwait_startup_hold", w_t'(cnt), w_t'(0));
    vid_req = 1'b0;
    mode = 1;
    lat = 3;
    repeat (3) @(negedge clk);
    do_txn(1'b0, 1'b0, 24'h000010, 16'h0000, 1'b0, "rstwait_served");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
